// File: rtl/bcd_2_binary_if.sv
// Handshake bundle for the BCD-to-binary converter: BCD word in, binary result out.
// master = producer/consumer side, slave = converter side.
interface bcd_2_binary_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    // Both sides follow one valid/ready rule: a word moves on a rising clk
    // edge where valid and ready are both high. A source holds its data
    // stable while valid is high and ready is low. Ready never depends
    // combinationally on valid.
    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, err
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, err
    );
endinterface

// File: rtl/bcd_2_binary.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first (acc = acc*10 + d).
// Digits above 9 set a sticky error and force the result to zero.
module bcd_2_binary #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_2_binary_if.slave        bus,
    output logic [1:0]           o_dbg_state
);
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [4*DIGITS-1:0] r_shift;
    logic [BIN_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic [BIN_W-1:0]    r_bin_out;
    logic                r_err_out;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [3:0]          w_digit;
    logic [BIN_W-1:0]    w_acc_next;
    logic                w_err_next;
    logic                w_last;

    assign w_digit    = r_shift[4*DIGITS-1 -: 4];
    // acc*10 as two shifts and an add, truncated to BIN_W
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_digit);
    assign w_err_next = r_err | (w_digit > 4'd9);
    assign w_last     = (r_cnt == CNT_W'(DIGITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_bin_out   <= '0;
            r_err_out   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_shift    <= bus.bcd_in;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_acc   <= w_acc_next;
                    r_err   <= w_err_next;
                    r_shift <= r_shift << 4;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bin_out   <= w_err_next ? '0 : w_acc_next;
                        r_err_out   <= w_err_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bin_out   = r_bin_out;
    assign bus.err       = r_err_out;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_bcd_2_binary.sv
// Directed bench for bcd_2_binary: reset, conversions, backpressure, bad digits, mid-op reset.
module tb_bcd_2_binary;
    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad   = 0;

    bcd_2_binary_if #(.DIGITS(3), .BIN_W(10)) bus ();

    bcd_2_binary #(.DIGITS(3), .BIN_W(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("wait_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // one full conversion with out_ready high; checks nominal latency
    task automatic convert(input string tag, input logic [11:0] bcd, input int exp_bin, input logic exp_err);
        wait_ready();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.bcd_in    = bcd;
        tick();                              // acceptance edge T
        bus.in_valid  = 1'b0;
        chk({tag, "_accept_ready"}, 32'(bus.in_ready), 32'd0);
        tick();
        chk({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, "_lat2_valid"}, 32'(bus.out_valid), 32'd0);
        tick();                              // T+3
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_ready_low"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        tick();                              // T+4
        chk({tag, "_ready_again"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;

        // asynchronous reset between edges
        #3 reset = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_bin_out", 32'(bus.bin_out), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_hold_ready", 32'(bus.in_ready), 32'd1);

        convert("c255", 12'h255, 255, 1'b0);
        convert("c000", 12'h000, 0, 1'b0);
        convert("c999", 12'h999, 999, 1'b0);
        convert("c100", 12'h100, 100, 1'b0);
        convert("c016", 12'h016, 16, 1'b0);

        // backpressure with an ignored word offered during the stall
        wait_ready();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.bcd_in    = 12'h042;
        tick();
        bus.in_valid  = 1'b0;
        tick();
        tick();
        tick();
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_bin", 32'(bus.bin_out), 32'd42);
        bus.in_valid = 1'b1;
        bus.bcd_in   = 12'h999;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_stall_bin", 32'(bus.bin_out), 32'd42);
            chk("bp_stall_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        chk("bp_ignored_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_ignored_valid", 32'(bus.out_valid), 32'd0);

        // invalid digit, then sticky flag must clear on the next accept
        convert("c1A3", 12'h1A3, 0, 1'b1);
        convert("c007", 12'h007, 7, 1'b0);

        // reset during the second CONV cycle discards the word
        wait_ready();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.bcd_in    = 12'h321;
        tick();
        bus.in_valid  = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_bin", 32'(bus.bin_out), 32'd0);
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_rst_no_valid", 32'(bus.out_valid), 32'd0);
        end
        convert("c123", 12'h123, 123, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
